alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle arithmetic/logic, multi-cycle 1-bit-per-cycle shifts, result held until accepted.
// Status flags (zero/neg/ovf) are built only when ALU_PIPE_FLAGS_EN is defined; otherwise they are tied to 0.
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;

   state_t           state_q;
   logic [WIDTH-1:0] sh_q;
   logic [SHW-1:0]   cnt_q;
   logic             shl_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [SHW-1:0]   amt;
   logic             is_shift;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic [WIDTH-1:0] alu_res_d;
   logic             alu_carry_d;
   logic [WIDTH-1:0] sh_next_d;
   logic             sh_out_d;
   logic             last_shift;
   logic             load_en;
   logic [WIDTH-1:0] load_res_d;
   logic             load_carry_d;

   assign amt      = b[SHW-1:0];
   assign is_shift = (op[2:1] == 2'b11);
   assign sum_w    = {1'b0, a} + {1'b0, b};
   assign diff_w   = {1'b0, a} - {1'b0, b};

   // Shift ops only reach this path with a zero amount, which passes a through.
   always_comb begin
      alu_res_d   = a;
      alu_carry_d = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res_d   = sum_w[WIDTH-1:0];
            alu_carry_d = sum_w[WIDTH];
         end
         OP_SUB: begin
            alu_res_d   = diff_w[WIDTH-1:0];
            alu_carry_d = diff_w[WIDTH];
         end
         OP_AND:  alu_res_d = a & b;
         OP_OR:   alu_res_d = a | b;
         OP_XOR:  alu_res_d = a ^ b;
         OP_NOT:  alu_res_d = ~a;
         default: alu_res_d = a;
      endcase
   end

   always_comb begin
      if (shl_q) begin
         sh_next_d = {sh_q[WIDTH-2:0], 1'b0};
         sh_out_d  = sh_q[WIDTH-1];
      end else begin
         sh_next_d = {1'b0, sh_q[WIDTH-1:1]};
         sh_out_d  = sh_q[0];
      end
   end

   assign last_shift = (state_q == SHIFT) && (cnt_q == SHW'(1));

   // One load point for the visible outputs, shared by the ALU and the shifter.
   always_comb begin
      load_en      = 1'b0;
      load_res_d   = alu_res_d;
      load_carry_d = alu_carry_d;
      if (state_q == IDLE && in_valid && !(is_shift && amt != '0)) begin
         load_en = 1'b1;
      end else if (last_shift) begin
         load_en      = 1'b1;
         load_res_d   = sh_next_d;
         load_carry_d = sh_out_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sh_q        <= '0;
         cnt_q       <= '0;
         shl_q       <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         if (load_en) begin
            result_q <= load_res_d;
            carry_q  <= load_carry_d;
         end
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  in_ready_q <= 1'b0;
                  if (is_shift && amt != '0) begin
                     sh_q    <= a;
                     cnt_q   <= amt;
                     shl_q   <= (op == OP_SHL);
                     state_q <= SHIFT;
                  end else begin
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            SHIFT: begin
               sh_q  <= sh_next_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == SHW'(1)) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry     = carry_q;

`ifdef ALU_PIPE_FLAGS_EN
   logic zero_q;
   logic neg_q;
   logic ovf_q;
   logic ovf_d;

   // Signed overflow: operands that should produce a given sign produced the other.
   always_comb begin
      ovf_d = 1'b0;
      if (state_q == IDLE) begin
         if (op == OP_ADD)
            ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
         else if (op == OP_SUB)
            ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (load_en) begin
         zero_q <= (load_res_d == '0);
         neg_q  <= load_res_d[WIDTH-1];
         ovf_q  <= ovf_d;
      end
   end

   assign zero = zero_q;
   assign neg  = neg_q;
   assign ovf  = ovf_q;
`else
   assign zero = 1'b0;
   assign neg  = 1'b0;
   assign ovf  = 1'b0;
`endif

endmodule
